// File: rtl/button_step_gen.sv
// Front-panel push-button conditioner: 2-FF sync, debounce, step pulses with hold-to-repeat, reset pulse.
// Define BTN_ACCEL_EN to switch to ACCEL_PERIOD after ACCEL_AFTER auto-repeat steps.
module button_step_gen #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000,
   parameter int ACCEL_AFTER     = 8,
   parameter int ACCEL_PERIOD    = 2_500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic up_raw,
   input  logic down_raw,
   input  logic rst_raw,
   output logic step_up,
   output logic step_down,
   output logic rst_pulse,
   output logic held
);
   localparam int              CW         = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0]     DELAY_LAST = 32'(REPEAT_DELAY - 1);
   // bit order {rst, down, up}; rst_raw is active-low so its released level is 1
   localparam logic [2:0]      RELEASED   = 3'b100;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
   typedef enum logic [1:0] {NONE, UP, DN} dir_t;

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
       ACCEL_AFTER < 0 || ACCEL_PERIOD < 2) begin : g_param_check
      $error("button_step_gen: parameter out of range");
   end

   logic [2:0]    raw;
   logic [2:0]    sync_p0;
   logic [2:0]    sync_p1;
   logic [2:0]    db;
   logic [CW-1:0] db_cnt [3];
   logic          db_rst_q;
   logic          rst_fall;
   state_t        state;
   dir_t          dir;
   dir_t          run_dir;
   logic [31:0]   tmr;
   logic [31:0]   period_last;

   assign raw      = {rst_raw, down_raw, up_raw};
   assign rst_fall = db_rst_q & ~db[2];

   // sync_p0 -> sync_p1 synchroniser, then per-button debounce counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0  <= RELEASED;
         sync_p1  <= RELEASED;
         db       <= RELEASED;
         db_rst_q <= 1'b1;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync_p0  <= raw;
         sync_p1  <= sync_p0;
         db_rst_q <= db[2];
         for (int i = 0; i < 3; i++) begin
            if (sync_p1[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= sync_p1[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      dir = NONE;
      if (db[0] && !db[1])      dir = UP;
      else if (db[1] && !db[0]) dir = DN;
   end

`ifdef BTN_ACCEL_EN
   logic [7:0] rep_cnt;

   assign period_last = (int'(rep_cnt) >= ACCEL_AFTER) ? 32'(ACCEL_PERIOD - 1)
                                                       : 32'(REPEAT_PERIOD - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rep_cnt <= '0;
      else if (state != REPEAT || rst_fall || dir != run_dir)
         rep_cnt <= '0;
      else if (tmr == period_last && rep_cnt != 8'hFF)
         rep_cnt <= rep_cnt + 8'd1;
   end
`else
   assign period_last = 32'(REPEAT_PERIOD - 1);
`endif

   // step FSM: outputs are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         run_dir   <= NONE;
         tmr       <= '0;
         step_up   <= 1'b0;
         step_down <= 1'b0;
         rst_pulse <= 1'b0;
         held      <= 1'b0;
      end else begin
         step_up   <= 1'b0;
         step_down <= 1'b0;
         rst_pulse <= rst_fall;
         if (rst_fall) begin
            // reset press wins over any step due now; a held direction re-arms from IDLE
            state <= IDLE;
            held  <= 1'b0;
            tmr   <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (dir != NONE) begin
                     step_up   <= (dir == UP);
                     step_down <= (dir == DN);
                     run_dir   <= dir;
                     tmr       <= '0;
                     state     <= DELAY;
                     held      <= 1'b1;
                  end
               end
               DELAY: begin
                  if (dir != run_dir) begin
                     state <= IDLE;
                     held  <= 1'b0;
                  end else if (tmr == DELAY_LAST) begin
                     step_up   <= (run_dir == UP);
                     step_down <= (run_dir == DN);
                     tmr       <= '0;
                     state     <= REPEAT;
                  end else begin
                     tmr <= tmr + 32'd1;
                  end
               end
               REPEAT: begin
                  if (dir != run_dir) begin
                     state <= IDLE;
                     held  <= 1'b0;
                  end else if (tmr == period_last) begin
                     step_up   <= (run_dir == UP);
                     step_down <= (run_dir == DN);
                     tmr       <= '0;
                  end else begin
                     tmr <= tmr + 32'd1;
                  end
               end
               default: begin
                  state <= IDLE;
                  held  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_button_step_gen.sv
// Self-checking bench for button_step_gen: randomized and directed stimulus against a schedule-based model.
module tb_button_step_gen;
   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 5;
   localparam int AA = 2;
   localparam int AP = 2;
`ifdef BTN_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic up_raw = 1'b0;
   logic down_raw = 1'b0;
   logic rst_raw = 1'b1;
   logic step_up, step_down, rst_pulse, held;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   button_step_gen #(
      .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
      .ACCEL_AFTER(AA), .ACCEL_PERIOD(AP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .up_raw(up_raw), .down_raw(down_raw), .rst_raw(rst_raw),
      .step_up(step_up), .step_down(step_down), .rst_pulse(rst_pulse), .held(held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference model: a level is accepted after D consecutive synced samples of the
   // opposite level; steps follow an absolute-time schedule once a direction is held.
   logic [2:0] rhist [$];
   logic [2:0] db_m;
   logic       dbr_q_m;
   bit         act;
   int         run_dir_m, nstep, mcyc, next_due;
   logic       exp_up = 1'b0, exp_dn = 1'b0, exp_rp = 1'b0, exp_held = 1'b0;
   int         d_m;
   logic       rf_m;
   bit         all_m;

   function automatic int gap_after(input int k);
      if (k == 0) return RD;
      if (ACCEL && (k - 1) >= AA) return AP;
      return RP;
   endfunction

   function automatic void model_reset();
      rhist.delete();
      for (int i = 0; i < D + 2; i++) rhist.push_back(3'b100);
      db_m = 3'b100; dbr_q_m = 1'b1; act = 0; run_dir_m = 0; nstep = 0;
      exp_up = 1'b0; exp_dn = 1'b0; exp_rp = 1'b0; exp_held = 1'b0;
   endfunction

   function automatic void fire();
      exp_up   = (run_dir_m == 1);
      exp_dn   = (run_dir_m == 2);
      next_due = mcyc + gap_after(nstep);
      nstep++;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         mcyc++;
         d_m  = (db_m[0] && !db_m[1]) ? 1 : (db_m[1] && !db_m[0]) ? 2 : 0;
         rf_m = dbr_q_m && !db_m[2];
         exp_up = 1'b0; exp_dn = 1'b0; exp_rp = rf_m;
         if (rf_m) act = 0;
         else if (act && d_m != run_dir_m) act = 0;
         else if (!act && d_m != 0) begin act = 1; run_dir_m = d_m; nstep = 0; fire(); end
         else if (act && mcyc == next_due) fire();
         exp_held = act;
         dbr_q_m = db_m[2];
         while (rhist.size() > D + 2) void'(rhist.pop_front());
         rhist.push_back({rst_raw, down_raw, up_raw});
         for (int b = 0; b < 3; b++) begin
            all_m = 1;
            for (int k = 0; k < D; k++)
               if (rhist[rhist.size() - 3 - k][b] == db_m[b]) all_m = 0;
            if (all_m) db_m[b] = ~db_m[b];
         end
      end
   end

   task automatic test_reset();
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold outputs got=%b exp=0000", {step_up, step_down, rst_pulse, held});
         end
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
      end
   endtask

   task automatic test_bounce();
      int ph, n_ev;
      ph = int'($urandom_range(0, 1));
      n_ev = 0;
      for (int i = 0; i < 52; i++) begin
         up_raw = (i < 40) ? 1'(((i + ph) / 2) % 2) : 1'b0;
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
         if (step_up || held) n_ev++;
      end
      checks++;
      if (n_ev !== 0) begin
         errors++;
         $display("FAIL bounce_quiet step_up/held cycles got=%0d exp=0", n_ev);
      end
   endtask

   task automatic test_single_press();
      int t0, n_up, t_up;
      n_up = 0; t_up = -1;
      t0 = cyc; up_raw = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL single cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
         if (step_up) begin n_up++; t_up = cyc; end
         if (i == 9) up_raw = 1'b0;
      end
      checks++;
      if (n_up !== 1) begin errors++; $display("FAIL single_count step_up got=%0d exp=1", n_up); end
      checks++;
      if (t_up - t0 !== 7) begin errors++; $display("FAIL single_latency got=%0d exp=7", t_up - t0); end
   endtask

   task automatic test_hold_repeat(input bit use_down);
      int t0, t, k, n_other;
      int got[$];
      int expt[$];
      n_other = 0;
      t = 7; k = 0;
      while (t <= 66) begin expt.push_back(t); t += gap_after(k); k++; end
      t0 = cyc;
      if (use_down) down_raw = 1'b1; else up_raw = 1'b1;
      for (int i = 0; i < 90; i++) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL hold cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
         if (use_down ? step_down : step_up) got.push_back(cyc - t0);
         if (use_down ? step_up : step_down) n_other++;
         if (i == 59) begin up_raw = 1'b0; down_raw = 1'b0; end
      end
      checks++;
      if (got.size() !== expt.size()) begin
         errors++;
         $display("FAIL hold_count dir=%0d got=%0d exp=%0d", use_down, got.size(), expt.size());
      end
      for (int j = 0; j < got.size() && j < expt.size(); j++) begin
         checks++;
         if (got[j] !== expt[j]) begin
            errors++;
            $display("FAIL hold_time dir=%0d step=%0d got=%0d exp=%0d", use_down, j, got[j], expt[j]);
         end
      end
      checks++;
      if (n_other !== 0) begin errors++; $display("FAIL hold_other_dir got=%0d exp=0", n_other); end
      got.delete();
      t0 = cyc;
      if (use_down) down_raw = 1'b1; else up_raw = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL repress cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
         if (use_down ? step_down : step_up) got.push_back(cyc - t0);
         if (i == 29) begin up_raw = 1'b0; down_raw = 1'b0; end
      end
      checks++;
      if (got.size() < 2) begin
         errors++;
         $display("FAIL repress_count got=%0d exp>=2", got.size());
      end else begin
         checks++;
         if (got[0] !== 7 || got[1] !== 27) begin
            errors++;
            $display("FAIL repress_restart got=%0d,%0d exp=7,27", got[0], got[1]);
         end
      end
   endtask

   task automatic test_dir_change();
      int t0, tdn, tu, n_late, held_chk;
      int dn[$];
      n_late = 0; held_chk = -1; tdn = 0; tu = 1 << 30;
      t0 = cyc; up_raw = 1'b1;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL dirchg cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
         if (i > 39 && cyc >= tdn + 7 && cyc <= tu + 6 && (step_up || step_down)) n_late++;
         if (i > 39 && cyc == tdn + 7) held_chk = int'(held);
         if (cyc > tu && step_down) dn.push_back(cyc - tu);
         if (i == 39) begin down_raw = 1'b1; tdn = cyc; end
         if (i == 54) begin up_raw = 1'b0; tu = cyc; end
         if (i == 99) down_raw = 1'b0;
      end
      checks++;
      if (n_late !== 0) begin errors++; $display("FAIL dirchg_stop late steps got=%0d exp=0", n_late); end
      checks++;
      if (held_chk !== 0) begin errors++; $display("FAIL dirchg_held got=%0d exp=0", held_chk); end
      checks++;
      if (dn.size() < 3) begin
         errors++;
         $display("FAIL dirchg_down_count got=%0d exp>=3", dn.size());
      end else begin
         checks++;
         if (dn[0] !== 7 || dn[1] !== 27 || dn[2] !== 32) begin
            errors++;
            $display("FAIL dirchg_down_times got=%0d,%0d,%0d exp=7,27,32", dn[0], dn[1], dn[2]);
         end
      end
   endtask

   task automatic test_rst_priority();
      int t0, tr, n_rp, t_rp, n_at;
      int ups[$];
      n_rp = 0; t_rp = -1; n_at = 0; tr = 1 << 30;
      t0 = cyc; up_raw = 1'b1;
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL rstpri cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
         if (rst_pulse) begin n_rp++; t_rp = cyc; if (step_up || step_down) n_at++; end
         if (cyc > tr + 7 && step_up) ups.push_back(cyc - tr);
         if (i == 39) begin rst_raw = 1'b0; tr = cyc; end
         if (i == 49) rst_raw = 1'b1;
         if (i == 79) up_raw = 1'b0;
      end
      checks++;
      if (n_rp !== 1) begin errors++; $display("FAIL rstpri_count got=%0d exp=1", n_rp); end
      checks++;
      if (t_rp - tr !== 7) begin errors++; $display("FAIL rstpri_latency got=%0d exp=7", t_rp - tr); end
      checks++;
      if (n_at !== 0) begin errors++; $display("FAIL rstpri_suppress got=%0d exp=0", n_at); end
      checks++;
      if (ups.size() < 2) begin
         errors++;
         $display("FAIL rstpri_rearm_count got=%0d exp>=2", ups.size());
      end else begin
         checks++;
         if (ups[0] !== 8 || ups[1] !== 28) begin
            errors++;
            $display("FAIL rstpri_rearm got=%0d,%0d exp=8,28", ups[0], ups[1]);
         end
      end
   endtask

   task automatic test_async_reset();
      int tr, t_first;
      t_first = -1;
      up_raw = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL areset_pre cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({step_up, step_down, rst_pulse, held} !== 4'b0000) begin
         errors++;
         $display("FAIL areset_immediate got=%b exp=0000", {step_up, step_down, rst_pulse, held});
      end
      @(negedge clk);
      rst_n = 1'b1; tr = cyc;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL areset_post cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
         if (step_up && t_first < 0) t_first = cyc - tr;
         if (i == 19) up_raw = 1'b0;
      end
      checks++;
      if (t_first !== 7) begin errors++; $display("FAIL areset_first_step got=%0d exp=7", t_first); end
   endtask

   task automatic test_random();
      logic [2:0] v;
      int len;
      for (int s = 0; s < 60; s++) begin
         v = 3'($urandom);
         len = int'($urandom_range(1, 40));
         up_raw = v[0]; down_raw = v[1];
         rst_raw = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
         for (int i = 0; i < len; i++) begin
            @(negedge clk);
            checks++;
            if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
               errors++;
               $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
            end
            checks++;
            if ((step_up & step_down) !== 1'b0) begin
               errors++;
               $display("FAIL random_exclusive cyc=%0d got=%b exp=0", cyc, step_up & step_down);
            end
         end
      end
      up_raw = 1'b0; down_raw = 1'b0; rst_raw = 1'b1;
      repeat (20) begin
         @(negedge clk);
         checks++;
         if ({step_up, step_down, rst_pulse, held} !== {exp_up, exp_dn, exp_rp, exp_held}) begin
            errors++;
            $display("FAIL random_tail cyc=%0d got=%b exp=%b", cyc, {step_up, step_down, rst_pulse, held}, {exp_up, exp_dn, exp_rp, exp_held});
         end
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_single_press();
      test_hold_repeat(1'b0);
      test_hold_repeat(1'b1);
      test_dir_change();
      test_rst_priority();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
